// File: rtl/scpu_out_capture.sv
// rtl/scpu_out_capture.sv - captures changes on the SCPU output bus into a FWFT FIFO
module scpu_out_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        cpu_out,
  input  logic                     cap_en,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [CNT_W-1:0]         chg_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count_q;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              ovf_q;
  logic [CNT_W-1:0]  chg_q;

  logic det;
  logic pop;
  logic push;
  logic full;

  // Change detection and FIFO handshake decode; a pop frees a slot for a same-cycle push
  always_comb begin
    full = (count_q == (AW+1)'(DEPTH));
    det  = cap_en & (~prev_valid | (cpu_out != prev));
    pop  = (count_q != '0) & out_ready;
    push = det & (~full | pop);
  end

  assign out_data   = mem[rd_ptr];
  assign out_valid  = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign chg_count  = chg_q;

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= cpu_out;
    end
  end

  // Pointers, occupancy, change tracking, counters and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      ovf_q      <= 1'b0;
      chg_q      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // prev follows every detected change, even a dropped one, so it is not re-detected
      if (det) begin
        prev       <= cpu_out;
        prev_valid <= 1'b1;
        if (chg_q != '1) begin
          chg_q <= chg_q + CNT_W'(1);
        end
      end
      // a drop in the same cycle as a clear leaves the flag set
      if (det & full & ~pop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scpu_out_capture.sv
// tb/tb_scpu_out_capture.sv - self-checking bench for scpu_out_capture
module tb_scpu_out_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_out;
  logic       cap_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       clr_ovf;
  logic [15:0] chg_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] got[$];
  logic [7:0] m_prev;
  bit         m_armed;
  bit         m_ovf;
  int         m_cnt;

  always #5 clk = ~clk;

  scpu_out_capture #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .cpu_out(cpu_out),
    .cap_en(cap_en),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .chg_count(chg_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    chk("out_valid", {31'd0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
    if (mq.size() != 0) chk("out_data", {24'd0, out_data}, {24'd0, mq[0]});
    chk("fifo_count", {28'd0, fifo_count}, mq.size());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("chg_count", {16'd0, chg_count}, m_cnt);
  endtask

  // check current outputs, advance the reference model with the applied inputs, clock once
  task automatic tick();
    bit pop;
    bit det;
    model_check();
    if (!rst) begin
      mq.delete();
      m_armed = 0;
      m_ovf   = 0;
      m_cnt   = 0;
      m_prev  = 8'h00;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      det = cap_en && (!m_armed || cpu_out != m_prev);
      if (pop) begin
        got.push_back(out_data);
        void'(mq.pop_front());
      end
      if (clr_ovf) m_ovf = 0;
      if (det) begin
        m_prev  = cpu_out;
        m_armed = 1;
        if (m_cnt < 65535) m_cnt++;
        if (mq.size() < 8) mq.push_back(cpu_out);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; cap_en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    rst = 1'b1;
    got.delete();
  endtask

  initial begin
    logic [7:0] seq2 [6];
    logic [7:0] exp2 [4];
    seq2 = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h01};
    exp2 = '{8'h01, 8'h02, 8'h03, 8'h01};
    m_prev = 8'h00; m_armed = 0; m_ovf = 0; m_cnt = 0;

    // reset held for two edges, then arm with a constant value
    rst = 1'b0; cap_en = 1'b0; cpu_out = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_chg", {16'd0, chg_count}, 32'd0);
    rst = 1'b1; cap_en = 1'b1; cpu_out = 8'h0f;
    tick();
    chk("arm_valid_1cyc", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 9; i++) tick();
    chk("arm_count", {28'd0, fifo_count}, 32'd1);
    chk("arm_chg", {16'd0, chg_count}, 32'd1);
    chk("arm_data", {24'd0, out_data}, 32'h0f);

    // change stream with a ready consumer
    do_reset();
    cap_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_out = seq2[i];
      tick();
    end
    for (int i = 0; i < 3; i++) tick();
    chk("stream_len", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("stream_data", {24'd0, got[i]}, {24'd0, exp2[i]});
    chk("stream_chg", {16'd0, chg_count}, 32'd4);
    chk("stream_count", {28'd0, fifo_count}, 32'd0);

    // overflow with a stalled consumer, then drain
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_out = 8'(i);
      tick();
    end
    chk("ovf_count", {28'd0, fifo_count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_chg", {16'd0, chg_count}, 32'd10);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    out_ready = 1'b0;
    chk("drain_len", got.size(), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_data", {24'd0, got[i]}, i);
    chk("drain_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // full FIFO with simultaneous pop and push
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_out = 8'(i);
      tick();
    end
    cpu_out = 8'hAA; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fullpp_count", {28'd0, fifo_count}, 32'd8);
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    chk("fullpp_head", {24'd0, out_data}, 32'h01);

    // clear versus set priority
    cpu_out = 8'hBB; clr_ovf = 1'b1;
    tick();
    chk("set_wins", {31'd0, overflow}, 32'd1);
    tick();
    clr_ovf = 1'b0;
    chk("clr_no_drop", {31'd0, overflow}, 32'd0);
    chk("prio_count", {28'd0, fifo_count}, 32'd8);

    // capture gating, then reset mid-run
    do_reset();
    cap_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cpu_out = 8'(i);
      tick();
    end
    cap_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_out = (i % 2 == 0) ? 8'h10 : 8'h20;
      tick();
    end
    chk("gate_count", {28'd0, fifo_count}, 32'd3);
    chk("gate_chg", {16'd0, chg_count}, 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_count", {28'd0, fifo_count}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_chg", {16'd0, chg_count}, 32'd0);
    cap_en = 1'b1; cpu_out = 8'h03;
    tick();
    chk("rearm_count", {28'd0, fifo_count}, 32'd1);
    chk("rearm_data", {24'd0, out_data}, 32'h03);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 99) != 0);
      cpu_out   = 8'($urandom_range(0, 3));
      cap_en    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
    end
    model_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
